// File: rtl/cache_cmd_sequencer.sv
// Trace-command sequencer for the split L1 caches: decodes one command per handshake, drives the
// read-then-write access sequence, the full-cache clear sweep, print requests and hit/miss stats.
module cache_cmd_sequencer #(
    parameter int unsigned SETS     = 16384,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [3:0]                           cmd_n,
    input  logic [ADDR_W-1:0]                    cmd_addr,
    output logic                                 sel_icache,
    output logic                                 read_enable,
    output logic                                 write_enable,
    output logic                                 clear_en,
    output logic [$clog2(SETS)-1:0]              set_index,
    output logic [ADDR_W-OFFSET_W-$clog2(SETS)-1:0] tag,
    input  logic                                 lookup_hit,
    output logic                                 print_req,
    output logic                                 done,
    output logic [CNT_W-1:0]                     reads,
    output logic [CNT_W-1:0]                     writes,
    output logic [CNT_W-1:0]                     hits,
    output logic [CNT_W-1:0]                     misses
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SETS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StEval,
        StUpdate,
        StClear,
        StPrint
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         n_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic               hit_q;
    logic [CNT_W-1:0]   reads_q, writes_q, hits_q, misses_q;

    logic accept;
    logic clear_last;
    logic count_op;

    // Byte-offset bits never select anything in the cache.
    logic unused_offset_bits;
    assign unused_offset_bits = ^cmd_addr[OFFSET_W-1:0];

    assign accept     = cmd_valid && cmd_ready;
    assign clear_last = (state_q == StClear) && (idx_q == LastIdx);
    assign count_op   = (n_q <= 4'd2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        clear_en     = 1'b0;
        print_req    = 1'b0;
        done         = 1'b0;
        sel_icache   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_n <= 4'd6) begin
                        state_d = StLookup;
                    end else if (cmd_n == 4'd8) begin
                        state_d = StClear;
                    end else begin
                        // Print and unsupported codes share the one-cycle completion path.
                        state_d = StPrint;
                    end
                end
            end
            StLookup: begin
                read_enable = 1'b1;
                sel_icache  = (n_q == 4'd2);
                state_d     = StEval;
            end
            StEval: begin
                sel_icache = (n_q == 4'd2);
                state_d    = StUpdate;
            end
            StUpdate: begin
                sel_icache   = (n_q == 4'd2);
                // Snoops only update a line that was actually present.
                write_enable = count_op || hit_q;
                done         = 1'b1;
                state_d      = StIdle;
            end
            StClear: begin
                clear_en     = 1'b1;
                write_enable = 1'b1;
                done         = clear_last;
                if (clear_last) begin
                    state_d = StIdle;
                end
            end
            StPrint: begin
                print_req = (n_q == 4'd9);
                done      = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                n_q   <= cmd_n;
                idx_q <= (cmd_n == 4'd8) ? '0 : cmd_addr[OFFSET_W +: IDX_W];
                tag_q <= cmd_addr[ADDR_W-1 -: TAG_W];
            end else if ((state_q == StClear) && !clear_last) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (state_q == StEval) begin
                hit_q <= lookup_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_last) begin
            reads_q  <= '0;
            writes_q <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else if ((state_q == StEval) && count_op) begin
            if (n_q == 4'd1) begin
                writes_q <= sat_inc(writes_q);
            end else begin
                reads_q <= sat_inc(reads_q);
            end
            if (lookup_hit) begin
                hits_q <= sat_inc(hits_q);
            end else begin
                misses_q <= sat_inc(misses_q);
            end
        end
    end

    assign set_index = idx_q;
    assign tag       = tag_q;
    assign reads     = reads_q;
    assign writes    = writes_q;
    assign hits      = hits_q;
    assign misses    = misses_q;

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Bench for cache_cmd_sequencer: a default-size instance and a small one (4 sets, 2-bit counters)
// checked cycle by cycle against a command-level reference model.
module tb_cache_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, lookup_hit, use_small;
    logic [3:0]  cmd_n;
    logic [31:0] cmd_addr;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_cnt [2][4];  // [instance][reads, writes, hits, misses]

    logic [3:0]  rn;
    logic [31:0] ra;
    logic        rh;

    always #5 clk = ~clk;

    logic        b_ready, b_sel, b_re, b_we, b_clr, b_pr, b_done;
    logic [13:0] b_idx;
    logic [11:0] b_tag;
    logic [31:0] b_reads, b_writes, b_hits, b_misses;
    logic        s_ready, s_sel, s_re, s_we, s_clr, s_pr, s_done;
    logic [1:0]  s_idx;
    logic [23:0] s_tag;
    logic [1:0]  s_reads, s_writes, s_hits, s_misses;

    cache_cmd_sequencer u_big (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !use_small), .cmd_ready(b_ready),
        .cmd_n(cmd_n), .cmd_addr(cmd_addr), .sel_icache(b_sel), .read_enable(b_re),
        .write_enable(b_we), .clear_en(b_clr), .set_index(b_idx), .tag(b_tag),
        .lookup_hit(lookup_hit), .print_req(b_pr), .done(b_done), .reads(b_reads),
        .writes(b_writes), .hits(b_hits), .misses(b_misses)
    );

    cache_cmd_sequencer #(.SETS(4), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && use_small), .cmd_ready(s_ready),
        .cmd_n(cmd_n), .cmd_addr(cmd_addr), .sel_icache(s_sel), .read_enable(s_re),
        .write_enable(s_we), .clear_en(s_clr), .set_index(s_idx), .tag(s_tag),
        .lookup_hit(lookup_hit), .print_req(s_pr), .done(s_done), .reads(s_reads),
        .writes(s_writes), .hits(s_hits), .misses(s_misses)
    );

    logic [6:0]  obs_flags;  // {ready, sel_icache, read, write, clear, print, done}
    logic [63:0] obs_idx, obs_tag;
    logic [63:0] obs_cnt [4];

    always_comb begin
        if (use_small) begin
            obs_flags  = {s_ready, s_sel, s_re, s_we, s_clr, s_pr, s_done};
            obs_idx    = 64'(s_idx);
            obs_tag    = 64'(s_tag);
            obs_cnt[0] = 64'(s_reads);
            obs_cnt[1] = 64'(s_writes);
            obs_cnt[2] = 64'(s_hits);
            obs_cnt[3] = 64'(s_misses);
        end else begin
            obs_flags  = {b_ready, b_sel, b_re, b_we, b_clr, b_pr, b_done};
            obs_idx    = 64'(b_idx);
            obs_tag    = 64'(b_tag);
            obs_cnt[0] = 64'(b_reads);
            obs_cnt[1] = 64'(b_writes);
            obs_cnt[2] = 64'(b_hits);
            obs_cnt[3] = 64'(b_misses);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", name, obs, exp);
        end
    endtask

    task automatic chk_flags(input string name, input bit rdy, input bit sel, input bit re,
                             input bit we, input bit clr, input bit pr, input bit dn);
        logic [6:0] e;
        e = {rdy, sel, re, we, clr, pr, dn};
        chk({name, " flags"}, 64'(obs_flags), 64'(e));
    endtask

    task automatic chk_cnt(input string name);
        int s;
        s = use_small ? 1 : 0;
        chk({name, " reads"},  obs_cnt[0], 64'(m_cnt[s][0]));
        chk({name, " writes"}, obs_cnt[1], 64'(m_cnt[s][1]));
        chk({name, " hits"},   obs_cnt[2], 64'(m_cnt[s][2]));
        chk({name, " misses"}, obs_cnt[3], 64'(m_cnt[s][3]));
    endtask

    function automatic longint sets_now();
        return use_small ? 64'd4 : 64'd16384;
    endfunction

    function automatic logic [63:0] exp_idx(input logic [31:0] a);
        return 64'((longint'(a) / 64) % sets_now());
    endfunction

    function automatic logic [63:0] exp_tag(input logic [31:0] a);
        return 64'(longint'(a) / (64 * sets_now()));
    endfunction

    task automatic bump(input int i);
        int s;
        longint mx;
        s  = use_small ? 1 : 0;
        mx = use_small ? 64'd3 : 64'hFFFF_FFFF;
        if (m_cnt[s][i] < mx) m_cnt[s][i]++;
    endtask

    task automatic zero_model(input int s);
        for (int i = 0; i < 4; i++) m_cnt[s][i] = 0;
    endtask

    // Access command: lookup_hit carries the real answer only in the cycle after read_enable.
    task automatic run_access(input logic [3:0] n, input logic [31:0] a, input bit hit);
        string t;
        t = $sformatf("n%0d", n);
        cmd_valid = 1'b1; cmd_n = n; cmd_addr = a; lookup_hit = !hit;
        step();
        chk_flags({t, " lookup"}, 0, n == 2, 1, 0, 0, 0, 0);
        chk({t, " index"}, obs_idx, exp_idx(a));
        chk({t, " tag"}, obs_tag, exp_tag(a));
        chk_cnt({t, " lookup"});
        cmd_n = 4'd8; cmd_addr = $urandom;  // must be ignored while busy
        step();
        chk_flags({t, " eval"}, 0, n == 2, 0, 0, 0, 0, 0);
        lookup_hit = hit;
        step();
        if (n <= 2) begin
            bump((n == 1) ? 1 : 0);
            bump(hit ? 2 : 3);
        end
        cmd_valid = 1'b0; lookup_hit = !hit;
        chk_flags({t, " update"}, 0, n == 2, 0, (n <= 2) || hit, 0, 0, 1);
        chk_cnt({t, " update"});
        step();
        chk_flags({t, " idle"}, 1, 0, 0, 0, 0, 0, 0);
        chk({t, " index hold"}, obs_idx, exp_idx(a));
        chk({t, " tag hold"}, obs_tag, exp_tag(a));
    endtask

    task automatic run_clear();
        longint sets;
        sets = sets_now();
        cmd_valid = 1'b1; cmd_n = 4'd8; cmd_addr = $urandom;
        step();
        cmd_valid = 1'b0;
        for (longint k = 1; k <= sets; k++) begin
            chk_flags("clear", 0, 0, 0, 1, 1, 0, k == sets);
            chk("clear index", obs_idx, 64'(k - 1));
            if (k == 1 || k == sets) chk_cnt("clear hold");
            step();
        end
        zero_model(use_small ? 1 : 0);
        chk_flags("clear end", 1, 0, 0, 0, 0, 0, 0);
        chk_cnt("clear end");
    endtask

    task automatic run_print(input logic [3:0] n);
        string t;
        t = $sformatf("n%0d", n);
        cmd_valid = 1'b1; cmd_n = n; cmd_addr = $urandom;
        step();
        cmd_valid = 1'b0;
        chk_flags({t, " print"}, 0, 0, 0, 0, 0, n == 9, 1);
        chk_cnt({t, " print"});
        step();
        chk_flags({t, " print idle"}, 1, 0, 0, 0, 0, 0, 0);
        chk_cnt({t, " print idle"});
    endtask

    initial begin
        use_small = 1'b0; rst = 1'b1; cmd_valid = 1'b0; cmd_n = '0; cmd_addr = '0;
        lookup_hit = 1'b0;
        zero_model(0);
        zero_model(1);
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            use_small = s[0];
            #1;
            chk_flags("reset", 1, 0, 0, 0, 0, 0, 0);
            chk("reset index", obs_idx, 64'd0);
            chk("reset tag", obs_tag, 64'd0);
            chk_cnt("reset");
        end
        rst = 1'b0; use_small = 1'b0;
        step();

        // Default-size instance: reads, writes, fetch, snoops, then a full sweep.
        run_access(4'd0, 32'h984DE132, 1'b0);
        run_access(4'd1, 32'h984DE132, 1'b1);
        run_access(4'd2, 32'h116DE12F, 1'b0);
        run_access(4'd4, 32'h0BADF00D, 1'b0);
        run_access(4'd4, 32'h0BADF00D, 1'b1);
        run_access(4'd3, 32'hFFFFFFC0, 1'b1);
        run_clear();
        run_access(4'd0, 32'h12345678, 1'b1);

        // Small instance: saturation, sweep with nonzero counters, print and unsupported codes.
        use_small = 1'b1;
        for (int i = 0; i < 5; i++) run_access(4'd0, 32'h000000C0 + 32'(i * 64), 1'b0);
        run_access(4'd1, 32'hA5A5A5A5, 1'b1);
        run_access(4'd2, 32'h5A5A5A40, 1'b1);
        run_clear();
        run_access(4'd1, 32'h00000040, 1'b1);
        run_print(4'd9);
        run_print(4'd7);
        run_print(4'd12);

        // Reset in the middle of a sweep.
        cmd_valid = 1'b1; cmd_n = 4'd8; cmd_addr = 32'h1234_5678;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("clear index before reset", obs_idx, 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        zero_model(0);
        zero_model(1);
        chk_flags("mid-clear reset", 1, 0, 0, 0, 0, 0, 0);
        chk_cnt("mid-clear reset");
        chk("mid-clear reset index", obs_idx, 64'd0);
        chk("mid-clear reset tag", obs_tag, 64'd0);
        run_access(4'd0, 32'h984DE132, 1'b0);

        // Random command mix on both instances; full-size sweeps are left to the directed part.
        for (int i = 0; i < 80; i++) begin
            use_small = 1'($urandom_range(0, 1));
            rn = 4'($urandom_range(0, 15));
            ra = $urandom;
            rh = 1'($urandom_range(0, 1));
            if (rn <= 4'd6) begin
                run_access(rn, ra, rh);
            end else if (rn == 4'd8) begin
                if (use_small) run_clear();
                else run_access(4'd2, ra, rh);
            end else begin
                run_print(rn);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
